// File: rtl/ss_dump_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Package    : ss_dump_streamer_pkg
// Description: Shared save-state space constants, FSM state type and the
//              transfer-length clamp used by the dump streamer.
// Revision   : 1.0 - initial release
// ============================================================================
package ss_dump_streamer_pkg;

  localparam int SS_AW   = 11;    // save-state address width
  localparam int SS_SIZE = 2048;  // bytes in the save-state space
  localparam int SS_LENW = 12;    // length/counter width, holds SS_SIZE exactly
  localparam int SS_DW   = 8;     // byte stream width
  localparam int SS_SUMW = 16;    // checksum width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ss_state_t;

  // Requests longer than the whole space are trimmed to one full pass.
  function automatic logic [SS_LENW-1:0] clamp_len(input logic [SS_LENW-1:0] len);
    return (len > SS_LENW'(SS_SIZE)) ? SS_LENW'(SS_SIZE) : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ss_dump_streamer_if.sv
`default_nettype none
// ============================================================================
// Interface  : ss_dump_streamer_if
// Description: Save-state read port plus the valid/ready byte stream towards
//              the host link. master = streamer side, slave = memory/host side.
// Revision   : 1.0 - initial release
// ============================================================================
interface ss_dump_streamer_if;
  import ss_dump_streamer_pkg::*;

  logic [SS_AW-1:0] rd_addr;
  logic             rd_req;
  logic [SS_DW-1:0] rd_data;
  logic [SS_DW-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    output rd_addr, rd_req, tx_data, tx_valid,
    input  rd_data, tx_ready
  );

  modport slave (
    input  rd_addr, rd_req, tx_data, tx_valid,
    output rd_data, tx_ready
  );

endinterface
`default_nettype wire

// File: rtl/ss_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module     : ss_byte_fifo
// Description: Synchronous byte FIFO with flush and occupancy count. DEPTH
//              must be a power of two so the pointers wrap naturally.
// Revision   : 1.0 - initial release
// ============================================================================
module ss_byte_fifo
  import ss_dump_streamer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     sys_rst,
  input  wire logic                     i_push,
  input  wire logic                     i_pop,
  input  wire logic                     i_flush,
  input  wire logic [SS_DW-1:0]         i_din,
  output logic      [SS_DW-1:0]         o_dout,
  output logic                          o_empty,
  output logic                          o_full,
  output logic      [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [SS_DW-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer and occupancy tracking; a flush empties the FIFO in one cycle.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

endmodule
`default_nettype wire

// File: rtl/ss_dump_streamer.sv
`default_nettype none
// ============================================================================
// Module     : ss_dump_streamer
// Description: Streams a window of the 2 KB save-state space out as a byte
//              stream. Reads are issued only against guaranteed FIFO space
//              (free slots minus reads still in flight), so the buffer can
//              never overflow. Keeps a 16-bit sum of accepted bytes.
// Revision   : 1.0 - initial release
// ============================================================================
module ss_dump_streamer
  import ss_dump_streamer_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic                clk,
  input  wire logic                sys_rst,
  input  wire logic                i_start,
  input  wire logic                i_abort,
  input  wire logic [SS_AW-1:0]    i_base_addr,
  input  wire logic [SS_LENW-1:0]  i_len,
  ss_dump_streamer_if.master       bus,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_aborted,
  output logic      [SS_SUMW-1:0]  o_sum
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ss_state_t          r_state;
  ss_state_t          w_state_nxt;
  logic [SS_AW-1:0]   r_addr;
  logic [SS_LENW-1:0] r_len;
  logic [SS_LENW-1:0] r_issued;
  logic [SS_LENW-1:0] r_accepted;
  logic [SS_SUMW-1:0] r_sum;
  logic [RD_LAT-1:0]  r_tag;
  logic               r_zero_done;
  logic               r_aborted;

  logic [SS_LENW-1:0] w_len_c;
  logic [SS_LENW-1:0] w_issued_inc;
  logic [CW-1:0]      w_count;
  logic [CW-1:0]      w_free;
  logic [CW-1:0]      w_inflight;
  logic [SS_DW-1:0]   w_dout;
  logic               w_empty;
  logic               w_full;
  logic               w_busy;
  logic               w_start_ok;
  logic               w_abort;
  logic               w_accept;
  logic               w_rd_req;
  logic               w_push;
  logic               w_last_acc;

  assign w_len_c      = clamp_len(i_len);
  assign w_busy       = (r_state != ST_IDLE);
  assign w_start_ok   = i_start && !w_busy;
  assign w_abort      = i_abort && w_busy;
  assign w_accept     = !w_empty && bus.tx_ready;
  assign w_free       = CW'(FIFO_DEPTH) - w_count;
  assign w_issued_inc = r_issued + SS_LENW'(1);
  assign w_rd_req     = (r_state == ST_RUN) && (r_issued < r_len) &&
                        (w_free > w_inflight) && !w_full;
  assign w_push       = r_tag[RD_LAT-1] && !w_abort;
  assign w_last_acc   = w_accept && (r_accepted == (r_len - SS_LENW'(1)));

  assign bus.rd_addr  = r_addr;
  assign bus.rd_req   = w_rd_req;
  assign bus.tx_data  = w_dout;
  assign bus.tx_valid = !w_empty;
  assign o_busy       = w_busy;
  assign o_aborted    = r_aborted;
  assign o_sum        = r_sum;

  // Count read tags still travelling through the latency pipe.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CW'(r_tag[i]);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state; done fires in the same cycle the last byte is accepted.
  always_comb begin
    w_state_nxt = r_state;
    o_done      = r_zero_done;
    case (r_state)
      ST_IDLE: begin
        if (i_start && (w_len_c != '0)) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_abort)                                     w_state_nxt = ST_IDLE;
        else if (w_rd_req && (w_issued_inc == r_len))    w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last_acc) begin
          w_state_nxt = ST_IDLE;
          o_done      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Address/issue/accept counters, checksum and the registered pulses.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_accepted  <= '0;
      r_sum       <= '0;
      r_zero_done <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_zero_done <= w_start_ok && (w_len_c == '0);
      r_aborted   <= w_abort;
      if (w_start_ok) begin
        r_addr     <= i_base_addr;
        r_len      <= w_len_c;
        r_issued   <= '0;
        r_accepted <= '0;
        r_sum      <= '0;
      end else begin
        if (w_rd_req) begin
          r_addr   <= r_addr + SS_AW'(1);
          r_issued <= w_issued_inc;
        end
        if (w_accept) begin
          r_accepted <= r_accepted + SS_LENW'(1);
          r_sum      <= r_sum + SS_SUMW'(w_dout);
        end
      end
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      // Single-stage tag pipe; an abort discards the read in flight.
      always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst)      r_tag <= '0;
        else if (w_abort) r_tag <= '0;
        else              r_tag <= w_rd_req;
      end
    end else begin : g_latn
      // Multi-stage tag pipe; an abort discards every read in flight.
      always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst)      r_tag <= '0;
        else if (w_abort) r_tag <= '0;
        else              r_tag <= {r_tag[RD_LAT-2:0], w_rd_req};
      end
    end
  endgenerate

  ss_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .sys_rst (sys_rst),
    .i_push  (w_push),
    .i_pop   (w_accept),
    .i_flush (w_abort),
    .i_din   (bus.rd_data),
    .o_dout  (w_dout),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_ss_dump_streamer.sv
`default_nettype none
// ============================================================================
// Module     : tb_ss_dump_streamer
// Description: Directed self-checking bench for ss_dump_streamer. The save
//              state memory returns mem[a] = a[7:0] one clock after rd_req.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_ss_dump_streamer;
  import ss_dump_streamer_pkg::*;

  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic        abort;
  logic [10:0] base;
  logic [11:0] len;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] sum;

  ss_dump_streamer_if bus ();

  ss_dump_streamer #(
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .i_start     (start),
    .i_abort     (abort),
    .i_base_addr (base),
    .i_len       (len),
    .bus         (bus),
    .o_busy      (busy),
    .o_done      (done),
    .o_aborted   (aborted),
    .o_sum       (sum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous read memory, one cycle of latency.
  initial bus.rd_data = '0;
  always @(posedge clk) if (bus.rd_req) bus.rd_data <= bus.rd_addr[7:0];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stream monitor state
  bit          mon_on = 1'b0;
  logic [10:0] exp_base;
  logic [10:0] mon_a;
  int acc_cnt, rd_cnt, order_errs, addr_errs, stall_errs, max_out, busy_cnt;
  int first_valid_cyc, first_acc_cyc, last_acc_cyc;
  int done_cnt, done_cyc, abort_cnt, abort_cyc;
  logic        abort_valid, abort_busy;
  logic [15:0] sum_sw;
  bit          prev_stall;
  logic [7:0]  prev_data;
  int          t_start;

  task automatic mon_clear(input logic [10:0] b);
    exp_base = b;
    acc_cnt = 0; rd_cnt = 0; order_errs = 0; addr_errs = 0; stall_errs = 0;
    max_out = 0; busy_cnt = 0; first_valid_cyc = -1; first_acc_cyc = -1;
    last_acc_cyc = -1; done_cnt = 0; done_cyc = -1; abort_cnt = 0; abort_cyc = -1;
    abort_valid = 1'b0; abort_busy = 1'b0; sum_sw = '0; prev_stall = 1'b0;
    prev_data = '0; mon_on = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_on && !sys_rst) begin
      if (bus.tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall && !(bus.tx_valid && bus.tx_data === prev_data)) stall_errs++;
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
      if (bus.rd_req) begin
        mon_a = exp_base + 11'(rd_cnt);
        if (bus.rd_addr !== mon_a) addr_errs++;
        rd_cnt++;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        mon_a = exp_base + 11'(acc_cnt);
        if (bus.tx_data !== mon_a[7:0]) order_errs++;
        sum_sw = sum_sw + 16'(bus.tx_data);
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        acc_cnt++;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (aborted) begin
        abort_cnt++; abort_cyc = cyc; abort_valid = bus.tx_valid; abort_busy = busy;
      end
      if (busy) busy_cnt++;
      if (rd_cnt - acc_cnt > max_out) max_out = rd_cnt - acc_cnt;
    end
  end

  // Called at posedge+1; start is sampled on the next rising edge.
  task automatic go(input logic [10:0] b, input logic [11:0] l);
    base = b; len = l; start = 1'b1; t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int limit);
    int k;
    k = 0;
    while (done_cnt == 0 && abort_cnt == 0 && k < limit) begin
      @(negedge clk); #1;
      k++;
    end
    if (done_cnt == 0 && abort_cnt == 0) check_eq("xfer_end_timeout", done_cnt + abort_cnt, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1; start = 1'b0; abort = 1'b0; base = '0; len = '0;
    bus.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy",     busy,         0);
    check_eq("rst_done",     done,         0);
    check_eq("rst_aborted",  aborted,      0);
    check_eq("rst_sum",      sum,          0);
    check_eq("rst_tx_valid", bus.tx_valid, 0);
    check_eq("rst_rd_req",   bus.rd_req,   0);
    check_eq("rst_rd_addr",  bus.rd_addr,  0);
    sys_rst = 1'b0;
    @(posedge clk); #1;

    // Basic 4-byte dump at full rate
    bus.tx_ready = 1'b1;
    mon_clear(11'h100);
    go(11'h100, 12'd4);
    wait_end(40);
    check_eq("t1_first_valid_lat", first_valid_cyc - t_start, 3);
    check_eq("t1_accepted",        acc_cnt,                   4);
    check_eq("t1_order",           order_errs,                0);
    check_eq("t1_back_to_back",    last_acc_cyc - first_acc_cyc, 3);
    check_eq("t1_done_cnt",        done_cnt,                  1);
    check_eq("t1_done_with_last",  done_cyc - last_acc_cyc,   0);
    check_eq("t1_sum",             sum,                       16'h0006);
    check_eq("t1_busy_after",      busy,                      0);

    // Address wrap at the top of the space
    mon_clear(11'h7FE);
    go(11'h7FE, 12'd4);
    wait_end(40);
    check_eq("t2_rd_cnt",   rd_cnt,     4);
    check_eq("t2_addr",     addr_errs,  0);
    check_eq("t2_order",    order_errs, 0);
    check_eq("t2_done_cnt", done_cnt,   1);
    check_eq("t2_sum",      sum,        16'h01FE);

    // Full 2048-byte pass with tx_ready toggling every clock
    mon_clear(11'h005);
    go(11'h005, 12'd2048);
    for (int k = 0; k < 6000 && done_cnt == 0; k++) begin
      @(posedge clk); #1;
      bus.tx_ready = ~bus.tx_ready;
    end
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("t3_done_cnt",   done_cnt,                  1);
    check_eq("t3_accepted",   acc_cnt,                   2048);
    check_eq("t3_rd_cnt",     rd_cnt,                    2048);
    check_eq("t3_order",      order_errs,                0);
    check_eq("t3_addr",       addr_errs,                 0);
    check_eq("t3_stall_hold", stall_errs,                0);
    check_eq("t3_buffer_ok",  32'(max_out <= FIFO_DEPTH), 1);
    check_eq("t3_sum_sw",     sum,                       sum_sw);
    check_eq("t3_sum",        sum,                       16'hFC00);

    // Oversized length clamps to 2048, full throughput
    mon_clear(11'h7FD);
    go(11'h7FD, 12'hFFF);
    wait_end(2300);
    check_eq("t3b_accepted",   acc_cnt,                      2048);
    check_eq("t3b_throughput", last_acc_cyc - first_acc_cyc, 2047);
    check_eq("t3b_order",      order_errs,                   0);
    check_eq("t3b_sum",        sum,                          16'hFC00);

    // Zero length: done one clock after start, no activity
    mon_clear(11'h000);
    go(11'h000, 12'd0);
    wait_end(10);
    check_eq("t4_done_cnt", done_cnt,           1);
    check_eq("t4_done_lat", done_cyc - t_start, 1);
    check_eq("t4_busy_cnt", busy_cnt,           0);
    check_eq("t4_rd_cnt",   rd_cnt,             0);
    check_eq("t4_sum",      sum,                0);

    // Abort during a stalled transfer
    mon_clear(11'h040);
    go(11'h040, 12'd16);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (cyc == t_start + 5) bus.tx_ready = 1'b0;
      abort = (cyc == t_start + 8);
    end
    abort = 1'b0;
    check_eq("t5_abort_cnt",  abort_cnt,           1);
    check_eq("t5_abort_lat",  abort_cyc - t_start, 9);
    check_eq("t5_abort_vld",  abort_valid,         0);
    check_eq("t5_abort_busy", abort_busy,          0);
    check_eq("t5_no_done",    done_cnt,            0);
    check_eq("t5_accepted",   acc_cnt,             2);
    check_eq("t5_sum",        sum,                 16'h0081);
    check_eq("t5_tx_valid",   bus.tx_valid,        0);

    // Abort while idle is ignored
    mon_clear(11'h000);
    abort = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    abort = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_abort_cnt",  abort_cnt, 0);
    check_eq("idle_abort_busy", busy_cnt,  0);

    // Restart with abort held alongside start: start wins, no stale bytes
    bus.tx_ready = 1'b1;
    mon_clear(11'h010);
    abort = 1'b1;
    go(11'h010, 12'd2);
    abort = 1'b0;
    wait_end(30);
    check_eq("t5r_accepted", acc_cnt,    2);
    check_eq("t5r_order",    order_errs, 0);
    check_eq("t5r_done",     done_cnt,   1);
    check_eq("t5r_no_abort", abort_cnt,  0);
    check_eq("t5r_sum",      sum,        16'h0021);

    // Start while busy is dropped, then reset mid-transfer
    mon_clear(11'h200);
    go(11'h200, 12'd8);
    repeat (2) begin @(posedge clk); #1; end
    base = 11'h300; len = 12'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check_eq("t6_busy_mid", busy,       1);
    check_eq("t6_addr",     addr_errs,  0);
    check_eq("t6_order",    order_errs, 0);
    #3;
    sys_rst = 1'b1;
    #1;
    check_eq("t6_rst_busy",     busy,         0);
    check_eq("t6_rst_tx_valid", bus.tx_valid, 0);
    check_eq("t6_rst_rd_req",   bus.rd_req,   0);
    check_eq("t6_rst_rd_addr",  bus.rd_addr,  0);
    check_eq("t6_rst_sum",      sum,          0);
    repeat (2) @(posedge clk);
    #1;
    sys_rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("t6_no_done",  done_cnt,  0);
    check_eq("t6_no_abort", abort_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
